timer_multi_channel: RTL and testbench

// - N-channel programmable down-counting timer with a shared register bus.
// - Generalises the single-channel CONTROL/LOAD/STATUS timer:
//   - per-channel prescaler, one-shot or auto-reload mode, readable live count;
//   - sticky expiry and overrun status, masked interrupt.
// - Sits on the SoC register bus. irq goes to the interrupt controller.

---
 rtl/timer_multi_channel_pkg.sv | 27 ++
 rtl/timer_channel.sv | 141 ++++++++++++++
 rtl/timer_multi_channel.sv | 95 +++++++++
 tb/tb_timer_multi_channel.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_multi_channel_pkg.sv
// Shared register map constants and register-select encoding for the multi-channel timer.
package timer_multi_channel_pkg;

    localparam int P_ADDR_CONTROL  = 'h00;
    localparam int P_ADDR_LOAD     = 'h04;
    localparam int P_ADDR_STATUS   = 'h08;
    localparam int P_ADDR_COUNT    = 'h0C;
    localparam int P_CH_STRIDE     = 'h10;

    localparam int P_BIT_START      = 0;
    localparam int P_BIT_RELOAD_EN  = 1;
    localparam int P_BIT_CLR_STATUS = 2;
    localparam int P_BIT_IRQ_EN     = 3;
    localparam int P_PRESC_LSB      = 8;

    localparam int P_BIT_EXPIRED = 0;
    localparam int P_BIT_OVERRUN = 1;

    // Word index within a channel's register block (byte offset / 4).
    typedef enum logic [1:0] {
        REG_CONTROL = 2'd0,
        REG_LOAD    = 2'd1,
        REG_STATUS  = 2'd2,
        REG_COUNT   = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/load registers, prescaler, down-counter and sticky status.
module timer_channel
    import timer_multi_channel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PRESC_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_we,
    input  logic                  load_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            rd_sel,
    output logic [DATA_WIDTH-1:0] rd_word,
    output logic                  expired,
    output logic                  irq_next
);

    logic                  start_reg, start_next;
    logic                  reload_en_reg, reload_en_next;
    logic                  irq_en_reg, irq_en_next;
    logic [PRESC_W-1:0]    presc_reg, presc_next;
    logic [PRESC_W-1:0]    pcnt_reg, pcnt_next;
    logic [DATA_WIDTH-1:0] load_reg, load_next;
    logic [DATA_WIDTH-1:0] count_reg, count_next;
    logic                  expired_st_reg, expired_st_next;
    logic                  overrun_st_reg, overrun_st_next;
    logic                  pulse_reg, pulse_next;
    logic                  tick;
    logic                  tick_eff;

    always_comb begin
        start_next      = start_reg;
        reload_en_next  = reload_en_reg;
        irq_en_next     = irq_en_reg;
        presc_next      = presc_reg;
        load_next       = load_reg;
        count_next      = count_reg;
        expired_st_next = expired_st_reg;
        overrun_st_next = overrun_st_reg;
        pulse_next      = 1'b0;

        tick = start_reg && (pcnt_reg == presc_reg);
        // A CONTROL write that stops the channel swallows a coincident tick.
        tick_eff = tick && !(ctrl_we && !wdata[P_BIT_START]);

        if (ctrl_we) begin
            start_next     = wdata[P_BIT_START];
            reload_en_next = wdata[P_BIT_RELOAD_EN];
            irq_en_next    = wdata[P_BIT_IRQ_EN];
            presc_next     = wdata[P_PRESC_LSB +: PRESC_W];
            if (wdata[P_BIT_CLR_STATUS]) begin
                expired_st_next = 1'b0;
                overrun_st_next = 1'b0;
            end
        end

        if (load_we) begin
            load_next = wdata;
        end

        if (tick_eff) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                // Expiry sets status after any clear above, so the set wins.
                pulse_next      = 1'b1;
                expired_st_next = 1'b1;
                if (expired_st_reg) begin
                    overrun_st_next = 1'b1;
                end
                if (reload_en_reg) begin
                    count_next = load_reg;
                end else if (!ctrl_we) begin
                    start_next = 1'b0;
                end
            end
        end

        if (load_we) begin
            count_next = wdata;
        end

        if (!start_reg || !start_next) begin
            pcnt_next = '0;
        end else if (tick) begin
            pcnt_next = '0;
        end else begin
            pcnt_next = pcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_reg      <= 1'b0;
            reload_en_reg  <= 1'b0;
            irq_en_reg     <= 1'b0;
            presc_reg      <= '0;
            pcnt_reg       <= '0;
            load_reg       <= '0;
            count_reg      <= '0;
            expired_st_reg <= 1'b0;
            overrun_st_reg <= 1'b0;
            pulse_reg      <= 1'b0;
        end else begin
            start_reg      <= start_next;
            reload_en_reg  <= reload_en_next;
            irq_en_reg     <= irq_en_next;
            presc_reg      <= presc_next;
            pcnt_reg       <= pcnt_next;
            load_reg       <= load_next;
            count_reg      <= count_next;
            expired_st_reg <= expired_st_next;
            overrun_st_reg <= overrun_st_next;
            pulse_reg      <= pulse_next;
        end
    end

    assign expired  = pulse_reg;
    assign irq_next = expired_st_next && irq_en_next;

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            REG_CONTROL: begin
                rd_word[P_BIT_START]              = start_reg;
                rd_word[P_BIT_RELOAD_EN]          = reload_en_reg;
                rd_word[P_BIT_IRQ_EN]             = irq_en_reg;
                rd_word[P_PRESC_LSB +: PRESC_W]   = presc_reg;
            end
            REG_LOAD:  rd_word = load_reg;
            REG_STATUS: begin
                rd_word[P_BIT_EXPIRED] = expired_st_reg;
                rd_word[P_BIT_OVERRUN] = overrun_st_reg;
            end
            REG_COUNT: rd_word = count_reg;
            default:   rd_word = '0;
        endcase
    end

endmodule

// File: rtl/timer_multi_channel.sv
// N-channel down-counting timer: address decode, registered read mux and irq combine.
module timer_multi_channel
    import timer_multi_channel_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PRESC_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  irq,
    output logic [N_CH-1:0]       expired
);

    localparam int STRIDE_LSB = $clog2(P_CH_STRIDE);
    localparam int CH_W       = ADDR_WIDTH - STRIDE_LSB;

    logic [CH_W-1:0]       ch_sel;
    logic [1:0]            reg_sel;
    logic                  aligned;
    logic [N_CH-1:0]       hit;
    logic [N_CH-1:0]       ch_irq;
    logic [DATA_WIDTH-1:0] rd_words [N_CH];
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  rvalid_reg;
    logic                  irq_reg;

    assign ch_sel  = addr[ADDR_WIDTH-1:STRIDE_LSB];
    assign reg_sel = addr[STRIDE_LSB-1:2];
    assign aligned = (addr[1:0] == 2'b00);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic ctrl_we;
            logic load_we;

            assign hit[gi]  = aligned && (ch_sel == CH_W'(gi));
            // STATUS and COUNT are read-only, so only these two offsets accept writes.
            assign ctrl_we  = req && we && hit[gi] && (reg_sel == REG_CONTROL);
            assign load_we  = req && we && hit[gi] && (reg_sel == REG_LOAD);

            timer_channel #(
                .DATA_WIDTH (DATA_WIDTH),
                .PRESC_W    (PRESC_W)
            ) u_channel (
                .clk      (clk),
                .rst      (rst),
                .ctrl_we  (ctrl_we),
                .load_we  (load_we),
                .wdata    (wdata),
                .rd_sel   (reg_sel),
                .rd_word  (rd_words[gi]),
                .expired  (expired[gi]),
                .irq_next (ch_irq[gi])
            );
        end
    endgenerate

    // Unmapped reads fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit[i]) begin
                rd_mux = rd_words[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            rvalid_reg <= req && !we;
            if (req && !we) begin
                rdata_reg <= rd_mux;
            end
            irq_reg <= |ch_irq;
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign irq    = irq_reg;

endmodule

// File: tb/tb_timer_multi_channel.sv
// Directed and randomized checks of timer_multi_channel against period/phase arithmetic.
module tb_timer_multi_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;
    logic [3:0]  expired;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    timer_multi_channel dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .irq     (irq),
        .expired (expired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic v);
        req = 1'b1; we = 1'b0; addr = a;
        step();
        req = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    // Count value t edges after a start, derived from the period formula.
    function automatic int exp_count(input int l, input int ps, input int t);
        int p;
        p = (l + 1) * (ps + 1);
        return l - ((t % p) / (ps + 1));
    endfunction

    task automatic run_concurrent(input bit randomize_cfg);
        int l [4];
        int ps [4];
        int t0 [4];
        logic [31:0] d;
        logic v;
        int rch;
        int t;
        do_reset();
        for (int ch = 0; ch < 4; ch++) begin
            l[ch]  = randomize_cfg ? int'($urandom_range(0, 6)) : ch + 1;
            ps[ch] = randomize_cfg ? int'($urandom_range(0, 3)) : 0;
            bus_write(8'(ch * 16 + 4), 32'(l[ch]));
        end
        for (int ch = 0; ch < 4; ch++) begin
            bus_write(8'(ch * 16), 32'((ps[ch] << 8) | 3));
            t0[ch] = cyc;
        end
        for (int k = 0; k < 40; k++) begin
            rch = int'($urandom_range(0, 3));
            bus_read(8'(rch * 16 + 12), d, v);
            check($sformatf("conc_rvalid k=%0d", k), 32'(v), 32'd1);
            check($sformatf("conc_count ch=%0d k=%0d", rch, k), d,
                  32'(exp_count(l[rch], ps[rch], cyc - 1 - t0[rch])));
            for (int ch = 0; ch < 4; ch++) begin
                t = cyc - t0[ch];
                check($sformatf("conc_pulse ch=%0d t=%0d", ch, t), 32'(expired[ch]),
                      32'((t % ((l[ch] + 1) * (ps[ch] + 1))) == 0));
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic v;
        int t0;
        int t;
        int pulses;

        // Reset state
        step();
        step();
        check("reset_rdata", rdata, 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_expired", 32'(expired), 32'd0);
        rst = 1'b0;
        bus_read(8'h0C, d, v);
        check("reset_count0", d, 32'd0);

        // Periodic reload on ch0, PRESCALE=0
        do_reset();
        bus_write(8'h04, 32'd3);
        bus_write(8'h00, 32'h0003);
        t0 = cyc;
        for (int k = 1; k <= 9; k++) begin
            bus_read(8'h08, d, v);
            t = cyc - t0;
            check($sformatf("periodic_pulse t=%0d", t), 32'(expired[0]), 32'((t % 4) == 0));
            check($sformatf("periodic_status t=%0d", t), d,
                  ((t - 1) / 4 >= 2) ? 32'h3 : (((t - 1) / 4 == 1) ? 32'h1 : 32'h0));
        end

        // One-shot with prescaler on ch2
        do_reset();
        bus_write(8'h24, 32'd2);
        bus_write(8'h20, 32'h0201);
        t0 = cyc;
        for (int k = 1; k <= 14; k++) begin
            step();
            t = cyc - t0;
            check($sformatf("oneshot_pulse t=%0d", t), 32'(expired[2]), 32'(t == 9));
        end
        bus_read(8'h20, d, v);
        check("oneshot_control", d, 32'h0200);
        bus_read(8'h2C, d, v);
        check("oneshot_count", d, 32'd0);

        // Irq and clear on ch1
        do_reset();
        bus_write(8'h14, 32'd1);
        bus_write(8'h10, 32'h0009);
        step();
        check("irq_low_before", 32'(irq), 32'd0);
        step();
        check("irq_high", 32'(irq), 32'd1);
        check("irq_pulse", 32'(expired[1]), 32'd1);
        bus_write(8'h10, 32'h000C);
        check("irq_cleared", 32'(irq), 32'd0);
        bus_read(8'h18, d, v);
        check("status_cleared", d, 32'd0);
        bus_write(8'h14, 32'd1);
        bus_write(8'h10, 32'h000B);
        step();
        step();
        step();
        bus_write(8'h10, 32'h000F);
        check("clr_vs_expiry_pulse", 32'(expired[1]), 32'd1);
        check("clr_vs_expiry_irq", 32'(irq), 32'd1);
        bus_read(8'h18, d, v);
        check("clr_vs_expiry_status", 32'(d[0]), 32'd1);

        // Concurrency: LOAD=ch+1 then a randomized configuration
        run_concurrent(1'b0);
        run_concurrent(1'b1);

        // Bus edges
        do_reset();
        bus_write(8'h04, 32'hA5);
        bus_read(8'h04, d, v);
        check("load_readback", d, 32'hA5);
        bus_read(8'h44, d, v);
        check("unmapped_ch_rdata", d, 32'd0);
        check("unmapped_ch_rvalid", 32'(v), 32'd1);
        bus_read(8'h02, d, v);
        check("misaligned_rdata", d, 32'd0);
        check("misaligned_rvalid", 32'(v), 32'd1);
        bus_write(8'h08, 32'hFFFF_FFFF);
        bus_read(8'h08, d, v);
        check("status_write_ignored", d, 32'd0);
        bus_write(8'h0C, 32'h55);
        bus_write(8'h05, 32'h77);
        bus_read(8'h0C, d, v);
        check("count_write_ignored", d, 32'hA5);
        bus_read(8'h04, d, v);
        check("misaligned_write_ignored", d, 32'hA5);
        bus_write(8'h34, 32'd1);
        bus_write(8'h30, 32'h0003);
        step();
        bus_write(8'h34, 32'h50);
        bus_read(8'h3C, d, v);
        check("load_on_expiry_count", d, 32'h50);

        // Reset mid-operation
        do_reset();
        bus_write(8'h14, 32'd0);
        bus_write(8'h10, 32'h0009);
        bus_write(8'h04, 32'd100);
        bus_write(8'h00, 32'h0003);
        for (int k = 0; k < 8; k++) step();
        bus_read(8'h0C, d, v);
        check("midcount_nonzero", 32'(d != 0), 32'd1);
        check("midcount_irq", 32'(irq), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_expired", 32'(expired), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 110; k++) begin
            step();
            if (expired != 4'd0) pulses++;
        end
        check("post_rst_no_pulse", 32'(pulses), 32'd0);
        bus_read(8'h0C, d, v);
        check("post_rst_count", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
